fetch_stage: RTL and testbench



---
 rtl/fetch_stage.sv | 80 ++++++++
 tb/tb_fetch_stage.sv | 107 ++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// fetch_stage: MIPS IF stage owning PC and cycle counter, registering fetched words into IF/ID with stall, redirect and halt/resume
module fetch_stage #(
  parameter int PC_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [31:0] HALT_INSTR = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                stall,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  input  logic                resume,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic [31:0]         imem_data,
  output logic [31:0]         id_instr,
  output logic [PC_WIDTH-1:0] id_pc_plus4,
  output logic                id_valid,
  output logic                halted,
  output logic [PC_WIDTH-1:0] pc,
  output logic [15:0]         cc
);
  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] pc_n, p4_n, pc_inc;
  logic [31:0] instr_n;
  logic valid_n;
  assign pc_inc = pc + PC_WIDTH'(4);
  assign imem_addr = pc;
  assign halted = state == HALT;
  // next PC, IF/ID contents and state: redirect > stall > halt-detect > normal fetch; HALT only listens to resume
  always_comb begin
    state_n = state;
    pc_n = pc;
    instr_n = id_instr;
    p4_n = id_pc_plus4;
    valid_n = id_valid;
    if (state == HALT) begin
      if (resume) begin
        pc_n = pc_inc;
        state_n = RUN;
      end
    end else if (redirect_valid) begin
      pc_n = {redirect_pc[PC_WIDTH-1:2], 2'b00};
      instr_n = NOP_INSTR;
      p4_n = '0;
      valid_n = 1'b0;
    end else if (!stall) begin
      if (imem_data == HALT_INSTR) begin
        instr_n = NOP_INSTR;
        p4_n = '0;
        valid_n = 1'b0;
        state_n = HALT;
      end else begin
        pc_n = pc_inc;
        instr_n = imem_data;
        p4_n = pc_inc;
        valid_n = 1'b1;
      end
    end
  end
  // state registers; the cycle counter only advances while running
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      pc <= RESET_PC;
      id_instr <= NOP_INSTR;
      id_pc_plus4 <= '0;
      id_valid <= 1'b0;
      cc <= '0;
    end else begin
      state <= state_n;
      pc <= pc_n;
      id_instr <= instr_n;
      id_pc_plus4 <= p4_n;
      id_valid <= valid_n;
      if (state == RUN) cc <= cc + 16'd1;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed scoreboard bench for fetch_stage
module tb_fetch_stage;
  logic clock = 1'b0;
  logic reset = 1'b1, stall = 1'b0, redirect_valid = 1'b0, resume = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic [15:0] imem_addr, id_pc_plus4, pc, cc;
  logic [31:0] imem_data, id_instr;
  logic id_valid, halted;
  logic [31:0] mem [64];
  int errors = 0, checks = 0;

  typedef struct {
    string name;
    logic [15:0] pc;
    logic [31:0] instr;
    logic [15:0] p4;
    logic v;
    logic h;
    logic [15:0] cc;
  } exp_t;
  exp_t q[$];

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .resume(resume), .imem_addr(imem_addr), .imem_data(imem_data),
    .id_instr(id_instr), .id_pc_plus4(id_pc_plus4), .id_valid(id_valid), .halted(halted),
    .pc(pc), .cc(cc)
  );

  always #5 clock = ~clock;
  assign imem_data = mem[imem_addr[7:2]];

  task automatic step(input string n, input logic rst, st, rv, input logic [15:0] rpc, input logic res,
                      input bit chk, input logic [15:0] epc, input logic [31:0] ei,
                      input logic [15:0] ep4, input logic ev, eh, input logic [15:0] ecc);
    exp_t e;
    @(negedge clock);
    reset = rst; stall = st; redirect_valid = rv; redirect_pc = rpc; resume = res;
    @(posedge clock);
    if (chk) begin
      e.name = n; e.pc = epc; e.instr = ei; e.p4 = ep4; e.v = ev; e.h = eh; e.cc = ecc;
      q.push_back(e);
    end
  endtask

  always @(negedge clock) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (pc !== e.pc || id_instr !== e.instr || id_valid !== e.v || halted !== e.h || cc !== e.cc ||
          (!$isunknown(e.p4) && id_pc_plus4 !== e.p4)) begin
        errors++;
        $display("FAIL %s: got pc=%h instr=%h p4=%h v=%b h=%b cc=%h, want pc=%h instr=%h p4=%h v=%b h=%b cc=%h",
                 e.name, pc, id_instr, id_pc_plus4, id_valid, halted, cc,
                 e.pc, e.instr, e.p4, e.v, e.h, e.cc);
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h0100_0000 | i;
    mem[0] = 32'h2001_0005; mem[1] = 32'h2002_0003; mem[2] = 32'h0022_1820;
    mem[3] = 32'h8C01_0000; mem[4] = 32'hFFFF_FFFF; mem[5] = 32'h0000_0001;
    mem[16] = 32'hAAAA_0040; mem[63] = 32'h1234_5678;
    //    name          rst st rv rpc       res chk pc        instr          p4        v  h  cc
    step("reset",       1, 0, 0, 16'h0,    0, 1, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'd0);
    step("fetch0",      0, 0, 0, 16'h0,    0, 1, 16'h0004, 32'h2001_0005, 16'h0004, 1, 0, 16'd1);
    step("fetch4",      0, 0, 0, 16'h0,    0, 1, 16'h0008, 32'h2002_0003, 16'h0008, 1, 0, 16'd2);
    step("fetch8",      0, 0, 0, 16'h0,    0, 1, 16'h000C, 32'h0022_1820, 16'h000C, 1, 0, 16'd3);
    step("stall1",      0, 1, 0, 16'h0,    0, 1, 16'h000C, 32'h0022_1820, 16'h000C, 1, 0, 16'd4);
    step("stall2",      0, 1, 0, 16'h0,    1, 1, 16'h000C, 32'h0022_1820, 16'h000C, 1, 0, 16'd5);
    step("release",     0, 0, 0, 16'h0,    0, 1, 16'h0010, 32'h8C01_0000, 16'h0010, 1, 0, 16'd6);
    step("halt_detect", 0, 0, 0, 16'h0,    0, 1, 16'h0010, 32'h0,         16'hxxxx, 0, 1, 16'd7);
    for (int i = 0; i < 5; i++)
      step("halt_hold", 0, i[0], i[1], 16'h0080, 0, 1, 16'h0010, 32'h0,   16'hxxxx, 0, 1, 16'd7);
    step("resume",      0, 0, 0, 16'h0,    1, 1, 16'h0014, 32'h0,         16'hxxxx, 0, 0, 16'd7);
    step("post_resume", 0, 0, 0, 16'h0,    1, 1, 16'h0018, 32'h0000_0001, 16'h0018, 1, 0, 16'd8);
    step("redir_stall", 0, 1, 1, 16'h0042, 0, 1, 16'h0040, 32'h0,         16'h0000, 0, 0, 16'd9);
    step("fetch40",     0, 0, 0, 16'h0,    0, 1, 16'h0044, 32'hAAAA_0040, 16'h0044, 1, 0, 16'd10);
    step("redir_fffc",  0, 0, 1, 16'hFFFD, 0, 1, 16'hFFFC, 32'h0,         16'h0000, 0, 0, 16'd11);
    step("pc_wrap",     0, 0, 0, 16'h0,    0, 1, 16'h0000, 32'h1234_5678, 16'h0000, 1, 0, 16'd12);
    step("stall_pre",   0, 1, 0, 16'h0,    0, 1, 16'h0000, 32'h1234_5678, 16'h0000, 1, 0, 16'd13);
    step("rst_stall",   1, 1, 0, 16'h0,    0, 1, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'd0);
    step("redir_10",    0, 0, 1, 16'h0010, 0, 1, 16'h0010, 32'h0,         16'h0000, 0, 0, 16'd1);
    step("halt2",       0, 0, 0, 16'h0,    0, 1, 16'h0010, 32'h0,         16'hxxxx, 0, 1, 16'd2);
    step("rst_halt",    1, 0, 0, 16'h0,    0, 1, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'd0);
    for (int i = 0; i < 65534; i++)
      step("cc_run",    0, 1, 0, 16'h0,    0, 0, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'd0);
    step("cc_ffff",     0, 1, 0, 16'h0,    0, 1, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'hFFFF);
    step("cc_wrap",     0, 1, 0, 16'h0,    0, 1, 16'h0000, 32'h0,         16'h0000, 0, 0, 16'h0000);
    @(negedge clock);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
